// File: rtl/spi_reg_frontend.sv
// SPI mode-0 slave front end: synchronises the SPI pins, decodes a command byte
// and performs one register-bank write or read per frame.
module spi_reg_frontend #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic [ADDR_W-1:0] reg_addr,
    input  logic [REG_W-1:0]  reg_data_i,
    output logic [REG_W-1:0]  reg_data_o,
    output logic              reg_data_o_dv,
    input  logic [REG_W-1:0]  status
);

    localparam int RX_W  = (REG_W > 8) ? REG_W : 8;
    localparam int CNT_W = $clog2(RX_W) + 1;
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(REG_W - 1);

    typedef enum logic [2:0] {IDLE, CMD, LOAD, DATA, DONE} state_t;

    state_t            state;
    logic [2:0]        cs_q;
    logic [2:0]        sclk_q;
    logic [1:0]        mosi_q;
    logic [RX_W-1:0]   rx;
    logic [REG_W-1:0]  tx;
    logic [CNT_W-1:0]  cnt;
    logic              rw;
    logic              first_fall;
    logic              wr_pend;

    logic              cs_high;
    logic              cs_fall;
    logic              sclk_rise;
    logic              sclk_fall;
    logic [RX_W-1:0]   rx_next;

    // CS sync resets low so a reset while CS is held low cannot fake a CS fall.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cs_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
        end else begin
            cs_q   <= {cs_q[1:0], spi_cs_n};
            sclk_q <= {sclk_q[1:0], spi_clk};
            mosi_q <= {mosi_q[0], spi_mosi};
        end
    end

    always_comb begin
        cs_high   = cs_q[1];
        cs_fall   = cs_q[2] & ~cs_q[1];
        sclk_rise = sclk_q[1] & ~sclk_q[2];
        sclk_fall = ~sclk_q[1] & sclk_q[2];
        rx_next   = {rx[RX_W-2:0], mosi_q[1]};
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state         <= IDLE;
            rx            <= '0;
            tx            <= '0;
            cnt           <= '0;
            rw            <= 1'b0;
            first_fall    <= 1'b0;
            wr_pend       <= 1'b0;
            spi_miso      <= 1'b0;
            reg_addr      <= '0;
            reg_data_o    <= '0;
            reg_data_o_dv <= 1'b0;
        end else begin
            wr_pend       <= 1'b0;
            reg_data_o_dv <= wr_pend;
            if (!ena) begin
                state         <= IDLE;
                spi_miso      <= 1'b0;
                reg_data_o_dv <= 1'b0;
            end else if (state != IDLE && cs_high) begin
                state    <= IDLE;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        spi_miso <= 1'b0;
                        if (cs_fall) begin
                            tx       <= status;
                            spi_miso <= status[REG_W-1];
                            cnt      <= '0;
                            state    <= CMD;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            rx <= rx_next;
                            if (cnt == CMD_LAST) begin
                                reg_addr <= rx_next[ADDR_W-1:0];
                                rw       <= rx_next[7];
                                cnt      <= '0;
                                state    <= LOAD;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            tx       <= {tx[REG_W-2:0], 1'b0};
                            spi_miso <= tx[REG_W-2];
                        end
                    end
                    LOAD: begin
                        tx         <= reg_data_i;
                        first_fall <= 1'b1;
                        state      <= DATA;
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            rx <= rx_next;
                            if (cnt == DATA_LAST) begin
                                if (rw) begin
                                    reg_data_o <= rx_next[REG_W-1:0];
                                    wr_pend    <= 1'b1;
                                end
                                spi_miso <= 1'b0;
                                state    <= DONE;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        // First fall after LOAD presents the loaded MSB without shifting.
                        if (sclk_fall) begin
                            if (first_fall) begin
                                spi_miso   <= tx[REG_W-1];
                                first_fall <= 1'b0;
                            end else begin
                                tx       <= {tx[REG_W-2:0], 1'b0};
                                spi_miso <= tx[REG_W-2];
                            end
                        end
                    end
                    DONE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        state    <= IDLE;
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_frontend.sv
// Scoreboard bench for spi_reg_frontend: SPI master stimulus, register-bank model,
// write-strobe and MISO monitors.
module tb_spi_reg_frontend;

    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic       spi_cs_n;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;
    logic [2:0] reg_addr;
    logic [7:0] reg_data_i;
    logic [7:0] reg_data_o;
    logic       reg_data_o_dv;
    logic [7:0] status;

    logic [7:0] regfile [0:7] = '{8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};

    int vectors = 0;
    int miscompares = 0;

    logic [2:0]  wr_addr_q [$];
    logic [7:0]  wr_data_q [$];
    logic [15:0] rd_exp_q [$];
    logic [15:0] rd_got_q [$];
    logic        dv_prev = 1'b0;

    spi_reg_frontend #(.ADDR_W(3), .REG_W(8)) dut (
        .clk          (clk),
        .rstb         (rstb),
        .ena          (ena),
        .spi_cs_n     (spi_cs_n),
        .spi_clk      (spi_clk),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .reg_addr     (reg_addr),
        .reg_data_i   (reg_data_i),
        .reg_data_o   (reg_data_o),
        .reg_data_o_dv(reg_data_o_dv),
        .status       (status)
    );

    always #5 clk = ~clk;

    assign reg_data_i = regfile[reg_addr];

    always @(posedge clk) begin
        if (reg_data_o_dv) regfile[reg_addr] <= reg_data_o;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Write-strobe monitor
    always @(negedge clk) begin
        if (reg_data_o_dv) begin
            chk("dv_width", {31'b0, dv_prev}, 32'd0);
            if (wr_addr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dv_unexpected: got dv with addr %0h data %0h expected no strobe",
                         reg_addr, reg_data_o);
            end else begin
                chk("wr_addr", {29'b0, reg_addr}, {29'b0, wr_addr_q.pop_front()});
                chk("wr_data", {24'b0, reg_data_o}, {24'b0, wr_data_q.pop_front()});
            end
        end
        dv_prev = reg_data_o_dv;
    end

    // MISO monitor
    initial begin
        forever begin
            wait (rd_got_q.size() > 0);
            if (rd_exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL miso_unexpected: got %0h expected nothing", rd_got_q.pop_front());
            end else begin
                chk("miso_word", {16'b0, rd_got_q.pop_front()}, {16'b0, rd_exp_q.pop_front()});
            end
        end
    end

    task automatic spi_bits(input logic [15:0] word, input int n, inout logic [15:0] got);
        for (int i = 0; i < n; i++) begin
            spi_mosi = word[15-i];
            #HALF;
            got = {got[14:0], spi_miso};
            spi_clk = 1'b1;
            #HALF;
            spi_clk = 1'b0;
        end
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] data, input int nd,
                         input int gap, output logic [15:0] got);
        got = '0;
        spi_cs_n = 1'b0;
        spi_bits({cmd, data}, 8 + nd, got);
        #HALF;
        spi_cs_n = 1'b1;
        #(gap * 10);
    endtask

    initial begin
        logic [15:0] got;
        rstb = 1'b0;
        ena = 1'b1;
        spi_cs_n = 1'b1;
        spi_clk = 1'b0;
        spi_mosi = 1'b0;
        status = 8'h5C;
        #32;
        chk("rst_miso", {31'b0, spi_miso}, 32'd0);
        chk("rst_addr", {29'b0, reg_addr}, 32'd0);
        chk("rst_data", {24'b0, reg_data_o}, 32'd0);
        chk("rst_dv", {31'b0, reg_data_o_dv}, 32'd0);
        @(negedge clk);
        rstb = 1'b1;
        #100;

        // Plain write
        wr_addr_q.push_back(3'd3); wr_data_q.push_back(8'hA5);
        frame(8'h83, 8'hA5, 8, 10, got);
        chk("wr_reg_addr", {29'b0, reg_addr}, 32'd3);
        chk("wr_reg_data", {24'b0, reg_data_o}, 32'hA5);

        // Read: status during command, bank data during data word
        rd_exp_q.push_back(16'h5CA5);
        frame(8'h03, 8'h00, 8, 10, got);
        rd_got_q.push_back(got);

        // Aborted write after 4 data bits, then a full one
        frame(8'h81, 8'h3C, 4, 10, got);
        chk("abort_data", {24'b0, reg_data_o}, 32'hA5);
        chk("abort_addr", {29'b0, reg_addr}, 32'd1);
        wr_addr_q.push_back(3'd1); wr_data_q.push_back(8'h3C);
        frame(8'h81, 8'h3C, 8, 10, got);

        // Disabled frame, then the same frame enabled
        ena = 1'b0;
        rd_exp_q.push_back(16'h0000);
        frame(8'h86, 8'h77, 8, 10, got);
        rd_got_q.push_back(got);
        chk("dis_addr", {29'b0, reg_addr}, 32'd1);
        ena = 1'b1;
        #50;
        wr_addr_q.push_back(3'd6); wr_data_q.push_back(8'h77);
        frame(8'h86, 8'h77, 8, 10, got);

        // Back-to-back writes with minimum CS-high gap
        for (int a = 0; a < 8; a++) begin
            wr_addr_q.push_back(3'(a)); wr_data_q.push_back(8'(a * 17));
            frame(8'h80 | 8'(a), 8'(a * 17), 8, 3, got);
        end
        #100;
        chk("b2b_addr", {29'b0, reg_addr}, 32'd7);
        chk("b2b_data", {24'b0, reg_data_o}, 32'h77);

        // Reset mid-command: outputs clear at once, rest of the frame is ignored
        got = '0;
        spi_cs_n = 1'b0;
        spi_bits(16'h8500, 4, got);
        rstb = 1'b0;
        #1;
        chk("mid_rst_miso", {31'b0, spi_miso}, 32'd0);
        chk("mid_rst_addr", {29'b0, reg_addr}, 32'd0);
        chk("mid_rst_data", {24'b0, reg_data_o}, 32'd0);
        chk("mid_rst_dv", {31'b0, reg_data_o_dv}, 32'd0);
        #19;
        rstb = 1'b1;
        spi_bits(16'h5FF0, 12, got);
        #HALF;
        spi_cs_n = 1'b1;
        #100;
        chk("post_rst_data", {24'b0, reg_data_o}, 32'd0);

        wr_addr_q.push_back(3'd2); wr_data_q.push_back(8'h5A);
        frame(8'h82, 8'h5A, 8, 10, got);
        rd_exp_q.push_back(16'h5C5A);
        frame(8'h02, 8'h00, 8, 10, got);
        rd_got_q.push_back(got);

        #200;
        chk("wr_pending", wr_addr_q.size(), 32'd0);
        chk("rd_pending", rd_exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/spi_reg_frontend.md
Name: spi_reg_frontend

Overview:
SPI mode-0 slave front end that converts serial SPI frames into register-bank accesses.
- Synchronises the external SPI pins into the clk domain.
- Decodes a command byte (R/W flag and address), then shifts one data word in (write) or out (read).
- Downstream: drives the register bank's address, write data and one-cycle write strobe.
- Upstream: pins of the chip's SPI interface.

Parameters:
ADDR_W, 3, register address width; must be 1..7.
REG_W, 8, register data width; must be at least 2.

Ports:
clk  input  1  system clock; must be at least 4x spi_clk frequency.
rstb  input  1  reset, asynchronous, active-low.
ena  input  1  block enable; low forces IDLE.
spi_cs_n  input  1  SPI chip select, active-low, asynchronous to clk.
spi_clk  input  1  SPI serial clock, asynchronous to clk.
spi_mosi  input  1  SPI serial data in, MSB first.
spi_miso  output  1  SPI serial data out, MSB first; registered in clk domain.
reg_addr  output  ADDR_W  register address from the last decoded command.
reg_data_i  input  REG_W  read data from the bank; combinational function of reg_addr.
reg_data_o  output  REG_W  write data to the bank.
reg_data_o_dv  output  1  write strobe, one clk cycle wide.
status  input  REG_W  status word shifted out during the command byte.

Behaviour:
Reset:
- Outputs all 0: spi_miso, reg_addr, reg_data_o, reg_data_o_dv.
- FSM in IDLE; shift registers and bit counter cleared.

Synchronisation:
- spi_cs_n, spi_clk and spi_mosi each pass through a 2-FF synchroniser.
- A third flop on spi_clk gives rise/fall detect pulses (1 clk each).
- A third flop on spi_cs_n gives the CS-fall detect pulse.
- All FSM actions occur on detect pulses. A pin edge produces its detect pulse on the 3rd clk edge after the pin change is first sampled.

Frame format:
- Command byte: 8 bits. Bit7 = RW (1 = write, 0 = read). Bits[6:ADDR_W] are ignored. Bits[ADDR_W-1:0] = address.
- Data word: REG_W bits, following the command byte.

FSM states and transitions:
- IDLE: spi_miso = 0. On CS-fall with ena = 1: capture status into the TX shift register, drive spi_miso = status MSB, clear bit counter, go to CMD.
- CMD: each SCLK rise shifts synced MOSI into the RX shift register and increments the counter. Each SCLK fall shifts TX left; spi_miso = TX MSB.
  - On the 8th rise: latch reg_addr and the RW flag, clear the counter, go to LOAD.
- LOAD (exactly 1 clk): TX <= reg_data_i, which is now valid for the new reg_addr. Go to DATA.
  - A write also loads TX; the value is harmless.
  - The next SCLK fall presents the data MSB on spi_miso (first fall after LOAD; no shift on that fall).
- DATA: shifting identical to CMD.
  - On the REG_W-th rise, write: reg_data_o <= RX contents including the final bit; reg_data_o_dv = 1 on the following clk cycle only.
  - Read: no strobe.
  - Go to DONE.
- DONE: extra SCLK edges are ignored; spi_miso = 0. Wait for CS high.

CS and enable handling:
- CS deassertion (synced) in any state: go to IDLE next cycle, spi_miso = 0.
  - A partial frame is discarded: no strobe, reg_data_o unchanged.
  - reg_addr keeps its value if already latched.
- Back-to-back frames need CS high for at least 3 clk cycles between them.
- ena = 0: FSM forced to IDLE, reg_data_o_dv = 0, spi_miso = 0. Registered outputs otherwise hold.
- Reset mid-frame: immediate return to reset values; the next frame starts only on a fresh CS-fall.

Latency and hold:
- reg_data_o_dv asserts 4 clk edges after the final SCLK rise is first sampled.
- reg_data_o and reg_addr hold until overwritten.
- Bit counter width is clog2(max(8, REG_W)) + 1. It never wraps within a frame.

Test Plan:
- Write frame: cmd 0x83, data 0xA5 at clk = 8x sclk → single 1-cycle dv pulse; reg_addr = 3; reg_data_o = 0xA5; no other dv pulses.
- Read frame: cmd 0x03 with reg_data_i model = 0xA5 at addr 3, status = 0x5C → MISO bits during cmd = 0x5C; during data = 0xA5; no dv.
- Abort: CS raised after 4 data bits of write cmd 0x81 → no dv; reg_data_o unchanged; next full write 0x81/0x3C succeeds (dv, data 0x3C).
- ena = 0 during a full write frame → no dv, spi_miso stays 0, reg_addr unchanged; ena = 1 with the same frame → write occurs.
- Back-to-back writes to addr 0..7 with data = addr*0x11, CS high for 3 clk between frames → 8 dv pulses, each with the correct addr/data.
- rstb pulsed mid-command byte → all outputs 0 immediately; the remaining SCLK edges of that frame produce no dv; the next frame works normally.
